pc_sequencer: RTL and testbench

Program-counter sequencer for the SPARC datapath: holds PC and produces the value loaded into the nPC register, implementing delay-slot semantics, annulled delay slots, DCTI targets and trap entry. It sits directly upstream of the nPC register; its `npc` output drives that register's data input, and the control unit pulses `advance` once per retired instruction. All outputs are registered. A two-state FSM gates advances after reset and trap entry.

---
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// SPARC PC/nPC sequencer: delay slots, annulled slots, DCTI targets, trap entry.
// Registered pc/npc/annul; a one-cycle SETTLE bubble follows reset and traps.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] RESET_NPC = 32'h00000004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic [1:0]  ctl_type,
  input  logic        cond_true,
  input  logic        is_uncond,
  input  logic        annul_bit,
  input  logic [31:0] target,
  input  logic        trap_req,
  input  logic [31:0] trap_vec,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        annul,
  output logic        ready
);

  typedef enum logic {
    SETTLE = 1'b0,
    RUN    = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_npc;
  logic        r_annul;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_npc_nxt;
  logic        w_annul_nxt;
  logic [31:0] w_seq;
  logic [31:0] w_tgt;
  logic [31:0] w_tvec;
  logic        w_step;
  logic        w_trap;
  logic        w_squash;
  logic        w_unused_lsb;

  assign w_step   = advance & (r_state == RUN);
  assign w_squash = r_annul;
  assign w_trap   = trap_req & ~r_annul;
  assign w_seq    = r_npc + 32'd4;
  assign w_tgt    = {target[31:2], 2'b00};
  assign w_tvec   = {trap_vec[31:2], 2'b00};

  assign w_unused_lsb = ^{target[1:0], trap_vec[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SETTLE;
      r_pc    <= RESET_PC;
      r_npc   <= RESET_NPC;
      r_annul <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_step) begin
        r_pc    <= w_pc_nxt;
        r_npc   <= w_npc_nxt;
        r_annul <= w_annul_nxt;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SETTLE: w_state_nxt = RUN;
      RUN: begin
        if (w_step && w_trap)
          w_state_nxt = SETTLE;
      end
      default: w_state_nxt = SETTLE;
    endcase
  end

  // Delay slot: pc always takes the old npc unless a trap redirects both.
  always_comb begin
    w_pc_nxt    = r_npc;
    w_npc_nxt   = w_seq;
    w_annul_nxt = 1'b0;
    unique case (1'b1)
      w_squash: begin
        w_npc_nxt = w_seq;
      end
      w_trap: begin
        w_pc_nxt  = w_tvec;
        w_npc_nxt = w_tvec + 32'd4;
      end
      default: begin
        unique case (ctl_type)
          2'b01: begin
            w_npc_nxt = cond_true ? w_tgt : w_seq;
            if (is_uncond)
              w_annul_nxt = annul_bit;
            else
              w_annul_nxt = annul_bit & ~cond_true;
          end
          2'b10:   w_npc_nxt = w_tgt;
          default: w_npc_nxt = w_seq;
        endcase
      end
    endcase
  end

  assign pc    = r_pc;
  assign npc   = r_npc;
  assign annul = r_annul;
  assign ready = (r_state == RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vectors, expected state queued per edge.
// A monitor pops each expectation one step after the clock and compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        advance = 1'b0;
  logic [1:0]  ctl_type = 2'b00;
  logic        cond_true = 1'b0;
  logic        is_uncond = 1'b0;
  logic        annul_bit = 1'b0;
  logic [31:0] target = 32'h0;
  logic        trap_req = 1'b0;
  logic [31:0] trap_vec = 32'h0;
  logic [31:0] pc, npc;
  logic        annul, ready;

  logic        rst1_n = 1'b0;
  logic        adv1 = 1'b0;
  logic [31:0] pc1, npc1;
  logic        annul1, ready1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        an;
    logic        rdy;
    string       nm;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  pc_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .advance(advance),
    .ctl_type(ctl_type), .cond_true(cond_true),
    .is_uncond(is_uncond), .annul_bit(annul_bit),
    .target(target), .trap_req(trap_req),
    .trap_vec(trap_vec), .pc(pc), .npc(npc),
    .annul(annul), .ready(ready)
  );

  pc_sequencer #(
    .RESET_PC(32'hFFFFFFF8),
    .RESET_NPC(32'hFFFFFFFC)
  ) u1 (
    .clk(clk), .rst_n(rst1_n), .advance(adv1),
    .ctl_type(2'b00), .cond_true(1'b0),
    .is_uncond(1'b0), .annul_bit(1'b0),
    .target(32'h0), .trap_req(1'b0),
    .trap_vec(32'h0), .pc(pc1), .npc(npc1),
    .annul(annul1), .ready(ready1)
  );

  task automatic chk(input string nm,
                     input logic [65:0] act,
                     input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%h npc=%h an=%b rdy=%b want pc=%h npc=%h an=%b rdy=%b",
               nm, act[65:34], act[33:2], act[1], act[0],
               exp[65:34], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic push(input bit sel, input logic [31:0] epc,
                      input logic [31:0] enpc, input logic ean,
                      input logic erdy, input string nm);
    exp_t e;
    e.sel = sel; e.pc = epc; e.npc = enpc;
    e.an = ean; e.rdy = erdy; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic drv(input logic adv, input logic [1:0] ct,
                     input logic ct_true, input logic unc,
                     input logic a, input logic [31:0] tgt,
                     input logic trq, input logic [31:0] tv,
                     input logic [31:0] epc, input logic [31:0] enpc,
                     input logic ean, input logic erdy,
                     input string nm);
    @(negedge clk);
    advance = adv; ctl_type = ct; cond_true = ct_true;
    is_uncond = unc; annul_bit = a; target = tgt;
    trap_req = trq; trap_vec = tv;
    push(1'b0, epc, enpc, ean, erdy, nm);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel)
        chk(e.nm, {pc1, npc1, annul1, ready1},
            {e.pc, e.npc, e.an, e.rdy});
      else
        chk(e.nm, {pc, npc, annul, ready},
            {e.pc, e.npc, e.an, e.rdy});
    end
  end

  initial begin
    advance = 1'b1;
    @(negedge clk);
    push(0, 32'h0, 32'h4, 0, 0, "rst_hold0");
    @(negedge clk);
    push(0, 32'h0, 32'h4, 0, 0, "rst_hold1");
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 32'h0, 32'h4, 0, 1, "settle_no_step");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h4, 32'h8, 0, 1, "seq_first");
    drv(1, 2'b10, 0, 0, 0, 32'h101, 0, 32'h0,
        32'h8, 32'h100, 0, 1, "call_align");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h100, 32'h104, 0, 1, "seq_to_100");
    drv(1, 2'b01, 1, 0, 1, 32'h200, 0, 32'h0,
        32'h104, 32'h200, 0, 1, "bicc_taken_a1");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h200, 32'h204, 0, 1, "taken_arrive");
    drv(1, 2'b10, 0, 0, 0, 32'h100, 0, 32'h0,
        32'h204, 32'h100, 0, 1, "call_100_b");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h100, 32'h104, 0, 1, "seq_to_100_b");
    drv(1, 2'b01, 0, 0, 1, 32'h200, 0, 32'h0,
        32'h104, 32'h108, 1, 1, "bicc_untaken_a1");
    drv(1, 2'b10, 0, 0, 0, 32'h300, 1, 32'h900,
        32'h108, 32'h10C, 0, 1, "squash_ign_trap");
    drv(1, 2'b10, 0, 0, 0, 32'h100, 0, 32'h0,
        32'h10C, 32'h100, 0, 1, "call_100_c");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h100, 32'h104, 0, 1, "seq_to_100_c");
    drv(1, 2'b01, 1, 1, 1, 32'h203, 0, 32'h0,
        32'h104, 32'h200, 1, 1, "ba_a1");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h200, 32'h204, 0, 1, "ba_slot_squash");
    drv(1, 2'b01, 0, 1, 1, 32'h500, 0, 32'h0,
        32'h204, 32'h208, 1, 1, "bn_a1");
    drv(1, 2'b01, 1, 0, 0, 32'h600, 0, 32'h0,
        32'h208, 32'h20C, 0, 1, "bn_slot_squash");
    drv(0, 2'b10, 0, 0, 0, 32'h700, 1, 32'h0,
        32'h208, 32'h20C, 0, 1, "no_advance_hold");
    drv(1, 2'b11, 1, 0, 1, 32'h700, 0, 32'h0,
        32'h20C, 32'h210, 0, 1, "reserved_seq");
    drv(1, 2'b01, 0, 0, 0, 32'h700, 0, 32'h0,
        32'h210, 32'h214, 0, 1, "untaken_a0");
    drv(1, 2'b10, 0, 0, 0, 32'h40, 0, 32'h0,
        32'h214, 32'h40, 0, 1, "call_40");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h40, 32'h44, 0, 1, "seq_to_40");
    drv(1, 2'b01, 1, 0, 1, 32'h200, 1, 32'h803,
        32'h800, 32'h804, 0, 0, "trap_entry");
    drv(1, 2'b10, 0, 0, 0, 32'h300, 1, 32'h900,
        32'h800, 32'h804, 0, 1, "trap_bubble");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h804, 32'h808, 0, 1, "post_trap_seq");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h808, 32'h80C, 0, 1, "pre_reset_seq");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {pc, npc, annul, ready},
        {32'h0, 32'h4, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 32'h0, 32'h4, 0, 1, "resettle");
    drv(1, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0,
        32'h4, 32'h8, 0, 1, "after_reset_seq");

    @(negedge clk);
    advance = 1'b0;
    rst1_n = 1'b1;
    adv1 = 1'b1;
    push(1, 32'hFFFFFFF8, 32'hFFFFFFFC, 0, 1, "wrap_settle");
    @(negedge clk);
    push(1, 32'hFFFFFFFC, 32'h0, 0, 1, "wrap_npc");
    @(negedge clk);
    push(1, 32'h0, 32'h4, 0, 1, "wrap_pc");
    @(negedge clk);
    adv1 = 1'b0;

    repeat (3) @(negedge clk);
    chk("queue_drained", {34'h0, 32'(q.size())}, 66'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
